// File: rtl/vga_pkg.sv
// Shared constants for the video line buffer: default geometry and the
// back-bank FSM state encoding.
package vga_pkg;

    localparam int VGA_BPP    = 6;
    localparam int VGA_DEPTH  = 4;
    localparam int VGA_IWIDTH = 2;

    // Back-bank fill state: FILL accepts writes, DONE waits for the reader.
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_DONE = 1'b1;

endpackage

// File: rtl/vline_bank.sv
// One line bank: DEPTH pixels of BPP bits, synchronous write, asynchronous
// read, synchronous clear. Out-of-range writes are dropped, reads return 0.
module vline_bank
    import vga_pkg::*;
#(
    parameter int BPP    = VGA_BPP,
    parameter int DEPTH  = VGA_DEPTH,
    parameter int IWIDTH = VGA_IWIDTH
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              i_we,
    input  logic [IWIDTH-1:0] i_waddr,
    input  logic [BPP-1:0]    i_wdata,
    input  logic [IWIDTH-1:0] i_raddr,
    output logic [BPP-1:0]    o_rdata
);

    logic [BPP-1:0] r_mem [DEPTH];

    // Clear on reset, otherwise write the addressed pixel if it exists.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_waddr == IWIDTH'(i)) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Address decode for the read port; unmatched addresses yield zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_raddr == IWIDTH'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/vline_buffer.sv
// Double-buffered video line store. The writer fills the back bank and
// commits it; the reader swaps banks at its line boundary. A swap with no
// committed line repeats the current front line and pulses Underrun.
// Optional feature: define VLINE_BUFFER_UNDERRUN_CNT_EN to add an 8-bit
// saturating UnderrunCount output.
module vline_buffer
    import vga_pkg::*;
#(
    parameter int BPP    = VGA_BPP,
    parameter int DEPTH  = VGA_DEPTH,
    parameter int IWIDTH = VGA_IWIDTH
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Write,
    input  logic [IWIDTH-1:0] WriteIndex,
    input  logic [BPP-1:0]    DataIn,
    input  logic              Commit,
    output logic              Ready,
    input  logic              Swap,
    input  logic [IWIDTH-1:0] ReadIndex,
    input  logic              Blank,
    output logic [BPP-1:0]    VideoOut,
    output logic              Underrun,
    output logic              FrontSel
`ifdef VLINE_BUFFER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]        UnderrunCount
`endif
);

    logic [0:0]     r_state;
    logic [0:0]     w_state_next;
    logic           r_ready;
    logic           r_front;
    logic           w_front_next;
    logic           r_underrun;
    logic           w_underrun_next;
    logic [BPP-1:0] r_video;

    logic           w_fill_we;
    logic           w_we0;
    logic           w_we1;
    logic [BPP-1:0] w_rdata0;
    logic [BPP-1:0] w_rdata1;
    logic [BPP-1:0] w_front_data;

    // Writes land only in the back bank and only while it is still filling.
    assign w_fill_we    = Write && (r_state == ST_FILL);
    assign w_we0        = w_fill_we && r_front;
    assign w_we1        = w_fill_we && !r_front;
    assign w_front_data = r_front ? w_rdata1 : w_rdata0;

    vline_bank #(
        .BPP    (BPP),
        .DEPTH  (DEPTH),
        .IWIDTH (IWIDTH)
    ) u_bank0 (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .i_we    (w_we0),
        .i_waddr (WriteIndex),
        .i_wdata (DataIn),
        .i_raddr (ReadIndex),
        .o_rdata (w_rdata0)
    );

    vline_bank #(
        .BPP    (BPP),
        .DEPTH  (DEPTH),
        .IWIDTH (IWIDTH)
    ) u_bank1 (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .i_we    (w_we1),
        .i_waddr (WriteIndex),
        .i_wdata (DataIn),
        .i_raddr (ReadIndex),
        .o_rdata (w_rdata1)
    );

    // Next-state logic for the back-bank FSM, bank select and underrun.
    // Commit together with Swap in FILL hands the line straight over.
    always_comb begin
        w_state_next    = r_state;
        w_front_next    = r_front;
        w_underrun_next = 1'b0;
        if (r_state == ST_FILL) begin
            if (Commit && Swap) begin
                w_front_next = ~r_front;
            end else if (Commit) begin
                w_state_next = ST_DONE;
            end else if (Swap) begin
                w_underrun_next = 1'b1;
            end
        end else begin
            if (Swap) begin
                w_front_next = ~r_front;
                w_state_next = ST_FILL;
            end
        end
    end

    // State, bank select, status flags and the registered video pixel.
    // The pixel uses the pre-edge bank select, so a swap shows next cycle.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state    <= ST_FILL;
            r_ready    <= 1'b1;
            r_front    <= 1'b0;
            r_underrun <= 1'b0;
            r_video    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ready    <= (w_state_next == ST_FILL);
            r_front    <= w_front_next;
            r_underrun <= w_underrun_next;
            r_video    <= Blank ? '0 : w_front_data;
        end
    end

`ifdef VLINE_BUFFER_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    // Saturating count of underrun events, updated with the pulse itself.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun_next && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
    end

    assign UnderrunCount = r_underrun_cnt;
`endif

    assign Ready    = r_ready;
    assign FrontSel = r_front;
    assign Underrun = r_underrun;
    assign VideoOut = r_video;

endmodule

// File: tb/tb_vline_buffer.sv
// Directed bench for vline_buffer with DEPTH=4 and a 3-bit index so that
// out-of-range addresses can be exercised.
module tb_vline_buffer;

    localparam int BPP    = 6;
    localparam int DEPTH  = 4;
    localparam int IWIDTH = 3;

    logic              Clk = 1'b0;
    logic              ResetN;
    logic              Write;
    logic [IWIDTH-1:0] WriteIndex;
    logic [BPP-1:0]    DataIn;
    logic              Commit;
    logic              Ready;
    logic              Swap;
    logic [IWIDTH-1:0] ReadIndex;
    logic              Blank;
    logic [BPP-1:0]    VideoOut;
    logic              Underrun;
    logic              FrontSel;
`ifdef VLINE_BUFFER_UNDERRUN_CNT_EN
    logic [7:0]        UnderrunCount;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    vline_buffer #(
        .BPP    (BPP),
        .DEPTH  (DEPTH),
        .IWIDTH (IWIDTH)
    ) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Write      (Write),
        .WriteIndex (WriteIndex),
        .DataIn     (DataIn),
        .Commit     (Commit),
        .Ready      (Ready),
        .Swap       (Swap),
        .ReadIndex  (ReadIndex),
        .Blank      (Blank),
        .VideoOut   (VideoOut),
        .Underrun   (Underrun),
        .FrontSel   (FrontSel)
`ifdef VLINE_BUFFER_UNDERRUN_CNT_EN
        ,
        .UnderrunCount (UnderrunCount)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       wr;
        logic [2:0] widx;
        logic [5:0] din;
        logic       cm;
        logic       sw;
        logic [2:0] ridx;
        logic       bl;
        logic [5:0] e_vid;
        logic       e_rdy;
        logic       e_und;
        logic       e_fs;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Write = 1'b0; WriteIndex = '0; DataIn = '0;
        Commit = 1'b0; Swap = 1'b0; ReadIndex = '0; Blank = 1'b0;
    endtask

    task automatic add(input logic wr, input logic [2:0] widx, input logic [5:0] din,
                       input logic cm, input logic sw, input logic [2:0] ridx, input logic bl,
                       input logic [5:0] e_vid, input logic e_rdy, input logic e_und,
                       input logic e_fs);
        vecs.push_back('{wr, widx, din, cm, sw, ridx, bl, e_vid, e_rdy, e_und, e_fs});
    endtask

    task automatic chk_all(input string tag, input int vid, input int rdy, input int und,
                           input int fs);
        chk({tag, " video"},    int'(VideoOut), vid);
        chk({tag, " ready"},    int'(Ready),    rdy);
        chk({tag, " underrun"}, int'(Underrun), und);
        chk({tag, " frontsel"}, int'(FrontSel), fs);
    endtask

    initial begin
        // Columns: wr widx din  cm sw ridx bl | video rdy und fs
        add(0, 0, 6'h00, 0, 0, 0, 0, 6'h00, 1, 0, 0); // 0 front bank cleared
        add(0, 0, 6'h00, 0, 0, 3, 0, 6'h00, 1, 0, 0); // 1
        add(1, 0, 6'h03, 0, 0, 0, 0, 6'h00, 1, 0, 0); // 2 fill bank1
        add(1, 1, 6'h0C, 0, 0, 0, 0, 6'h00, 1, 0, 0); // 3
        add(1, 2, 6'h30, 0, 0, 0, 0, 6'h00, 1, 0, 0); // 4
        add(1, 3, 6'h3F, 1, 0, 0, 0, 6'h00, 0, 0, 0); // 5 last write + commit
        add(1, 0, 6'h15, 0, 0, 0, 0, 6'h00, 0, 0, 0); // 6 write in DONE dropped
        add(0, 0, 6'h00, 0, 1, 2, 0, 6'h00, 1, 0, 1); // 7 swap reads old front
        add(0, 0, 6'h00, 0, 0, 2, 0, 6'h30, 1, 0, 1); // 8 new line visible
        add(0, 0, 6'h00, 0, 0, 0, 0, 6'h03, 1, 0, 1); // 9 0x15 did not land
        add(0, 0, 6'h00, 0, 0, 3, 0, 6'h3F, 1, 0, 1); // 10
        add(0, 0, 6'h00, 0, 0, 1, 0, 6'h0C, 1, 0, 1); // 11
        add(0, 0, 6'h00, 0, 0, 5, 0, 6'h00, 1, 0, 1); // 12 out-of-range read
        add(0, 0, 6'h00, 0, 0, 2, 1, 6'h00, 1, 0, 1); // 13 blank
        add(0, 0, 6'h00, 0, 1, 1, 0, 6'h0C, 1, 1, 1); // 14 underrun
        add(0, 0, 6'h00, 0, 0, 1, 0, 6'h0C, 1, 0, 1); // 15 pulse ends, line repeats
        add(1, 0, 6'h2A, 0, 0, 1, 0, 6'h0C, 1, 0, 1); // 16 fill bank0
        add(1, 4, 6'h11, 0, 0, 1, 0, 6'h0C, 1, 0, 1); // 17 out-of-range write
        add(1, 1, 6'h01, 1, 0, 1, 0, 6'h0C, 0, 0, 1); // 18 commit
        add(0, 0, 6'h00, 0, 1, 0, 0, 6'h03, 1, 0, 0); // 19 swap
        add(0, 0, 6'h00, 0, 0, 0, 0, 6'h2A, 1, 0, 0); // 20
        add(0, 0, 6'h00, 0, 0, 1, 0, 6'h01, 1, 0, 0); // 21
        add(0, 0, 6'h00, 0, 0, 2, 0, 6'h00, 1, 0, 0); // 22
        add(1, 2, 6'h07, 1, 1, 3, 0, 6'h00, 1, 0, 1); // 23 commit+swap in FILL
        add(0, 0, 6'h00, 0, 0, 2, 0, 6'h07, 1, 0, 1); // 24 same-cycle write kept
        add(0, 0, 6'h00, 0, 0, 0, 0, 6'h03, 1, 0, 1); // 25

        // Reset for two cycles with a write pending.
        idle();
        ResetN = 1'b0;
        Write = 1'b1; WriteIndex = 3'd1; DataIn = 6'h3F;
        tick();
        tick();
        chk_all("reset", 0, 1, 0, 0);
`ifdef VLINE_BUFFER_UNDERRUN_CNT_EN
        chk("reset count", int'(UnderrunCount), 0);
`endif
        ResetN = 1'b1;
        idle();

        foreach (vecs[i]) begin
            Write = vecs[i].wr; WriteIndex = vecs[i].widx; DataIn = vecs[i].din;
            Commit = vecs[i].cm; Swap = vecs[i].sw; ReadIndex = vecs[i].ridx;
            Blank = vecs[i].bl;
            tick();
            chk_all($sformatf("row%0d", i), int'(vecs[i].e_vid), int'(vecs[i].e_rdy),
                    int'(vecs[i].e_und), int'(vecs[i].e_fs));
        end
        idle();

`ifdef VLINE_BUFFER_UNDERRUN_CNT_EN
        chk("count after one underrun", int'(UnderrunCount), 1);
        // Now in FILL; 300 distinct swap pulses all miss.
        for (int k = 0; k < 300; k++) begin
            Swap = 1'b1;
            tick();
            Swap = 1'b0;
            tick();
        end
        chk("count saturated", int'(UnderrunCount), 255);
        chk("frontsel after underruns", int'(FrontSel), 1);
`endif

        // Partial fill of bank0, then reset with every control asserted.
        Write = 1'b1; WriteIndex = 3'd3; DataIn = 6'h22;
        tick();
        ResetN = 1'b0;
        Write = 1'b1; WriteIndex = 3'd0; DataIn = 6'h3F;
        Commit = 1'b1; Swap = 1'b1; ReadIndex = 3'd0;
        tick();
        chk_all("reset prio", 0, 1, 0, 0);
        ResetN = 1'b1;
        idle();
        ReadIndex = 3'd0;
        tick();
        chk("cleared bank0 idx0", int'(VideoOut), 0);
        ReadIndex = 3'd3;
        tick();
        chk("cleared bank0 idx3", int'(VideoOut), 0);
        Commit = 1'b1;
        tick();
        chk("ready after commit", int'(Ready), 0);
        Commit = 1'b0; Swap = 1'b1;
        tick();
        chk("frontsel after swap", int'(FrontSel), 1);
        Swap = 1'b0; ReadIndex = 3'd0;
        tick();
        chk("cleared bank1 idx0", int'(VideoOut), 0);
        ReadIndex = 3'd2;
        tick();
        chk("cleared bank1 idx2", int'(VideoOut), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vline_buffer.md
VLINE_BUFFER -- requirements
Module: vline_buffer

Interface
REQ-001 SHALL have parameter BPP, default 6, bits per pixel.
REQ-002 SHALL have parameter DEPTH, default 4, pixels per bank.
REQ-003 SHALL have parameter IWIDTH, default 2, index width; DEPTH <= 2**IWIDTH.
REQ-004 SHALL have port Clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port ResetN  input  1  synchronous, active-low reset.
REQ-006 SHALL have port Write  input  1  write strobe into back bank.
REQ-007 SHALL have port WriteIndex  input  IWIDTH  back-bank write address.
REQ-008 SHALL have port DataIn  input  BPP  write pixel.
REQ-009 SHALL have port Commit  input  1  writer declares back bank complete.
REQ-010 SHALL have port Ready  output  1  back bank accepts writes.
REQ-011 SHALL have port Swap  input  1  reader line boundary; swap point.
REQ-012 SHALL have port ReadIndex  input  IWIDTH  front-bank read address.
REQ-013 SHALL have port Blank  input  1  force video output to zero.
REQ-014 SHALL have port VideoOut  output  BPP  registered pixel output.
REQ-015 SHALL have port Underrun  output  1  one-cycle pulse on missed swap.
REQ-016 SHALL have port FrontSel  output  1  index of bank currently displayed.

Function
REQ-017 SHALL hold two banks of DEPTH x BPP; front = FrontSel, back = ~FrontSel.
REQ-018 SHALL run a back-bank FSM with states FILL (Ready=1) and DONE (Ready=0); Ready is registered from the state.
REQ-019 SHALL in FILL write DataIn to back[WriteIndex] when Write=1; Write in DONE is ignored.
REQ-020 SHALL in FILL move to DONE on Commit=1; Write and Commit in the same cycle both take effect.
REQ-021 SHALL on Swap=1 in DONE toggle FrontSel and return to FILL next cycle.
REQ-022 SHALL on Swap=1 in FILL keep FrontSel, keep state, and pulse Underrun for one cycle; the front line repeats.
REQ-023 SHALL treat Commit and Swap together in FILL as a committed swap: FrontSel toggles, state stays FILL, no Underrun.
REQ-024 SHALL drive VideoOut with one-cycle latency: 0 if Blank, else front[ReadIndex] as sampled pre-edge.
REQ-025 SHALL read from the pre-swap front bank in a Swap cycle; the new bank is visible from the next cycle.
REQ-026 SHALL ignore writes with WriteIndex >= DEPTH and return 0 for reads with ReadIndex >= DEPTH.

Reset
REQ-027 SHALL when ResetN=0 at an edge set VideoOut=0, FrontSel=0, state FILL, Ready=1, Underrun=0, and clear both banks to 0.
REQ-028 SHALL give reset priority over Write, Commit and Swap in the same cycle; partial fills are discarded.

Configuration
REQ-029 SHALL with macro VLINE_BUFFER_UNDERRUN_CNT_EN defined add output UnderrunCount (8 bits), incremented on each Underrun pulse, saturating at 255, reset to 0.
REQ-030 SHALL without VLINE_BUFFER_UNDERRUN_CNT_EN omit the UnderrunCount port and counter; all other behaviour is identical.

Structure
REQ-031 SHALL place the FSM state encoding (FILL=0, DONE=1) and the default BPP/DEPTH/IWIDTH constants in shared package vga_pkg.
REQ-032 SHALL implement one bank as sub-module vline_bank (sync write, async read, sync clear); vline_buffer instantiates two.

Verification
REQ-033 SHALL cover reset: ResetN=0 for 2 cycles with Write=1 -> VideoOut=0, Ready=1, FrontSel=0, banks read 0.
REQ-034 SHALL cover fill and swap: write 0x03,0x0C,0x30,0x3F to indices 0..3, Commit, then Swap -> FrontSel=1; ReadIndex=2 gives VideoOut=0x30 one cycle later.
REQ-035 SHALL cover underrun: Swap while FILL -> Underrun=1 for exactly 1 cycle, FrontSel unchanged, old line still readable; counter=1 with the macro.
REQ-036 SHALL cover blank and locking: Blank=1 -> VideoOut=0 next cycle; Write 0x15 in DONE -> back bank unchanged after the swap.
REQ-037 SHALL cover simultaneous events: Commit+Swap in FILL -> swap with no Underrun; ReadIndex=5 with DEPTH=4, IWIDTH=3 -> VideoOut=0.
REQ-038 SHALL cover saturation (macro on): 300 underruns -> UnderrunCount=255.
